// File: rtl/regfile_mp_if.sv
// regfile_mp_if: Index-stage to register-bank request/response bundle.
// master drives requests and write-back; slave is the register bank.
interface regfile_mp_if #(
    parameter int NUM_RD     = 3,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 6,
    parameter int NO_WIDTH   = 2
);
    logic                           I_Req;
    logic [NUM_RD-1:0]              I_Rd_V;
    logic [NUM_RD*NO_WIDTH-1:0]     I_Rd_No;
    logic [NUM_RD*IDX_WIDTH-1:0]    I_Rd_Idx;
    logic                           I_We;
    logic [IDX_WIDTH-1:0]           I_Wr_Idx;
    logic [DATA_WIDTH-1:0]          I_Data;
    logic                           I_Rsv;
    logic [IDX_WIDTH-1:0]           I_Rsv_Idx;
    logic                           I_Clr;
    logic [NUM_RD-1:0]              O_Valid;
    logic [NUM_RD*DATA_WIDTH-1:0]   O_Data;
    logic [NUM_RD-1:0]              O_Busy;

    modport master (
        output I_Req, I_Rd_V, I_Rd_No, I_Rd_Idx,
        output I_We, I_Wr_Idx, I_Data,
        output I_Rsv, I_Rsv_Idx, I_Clr,
        input  O_Valid, O_Data, O_Busy
    );

    modport slave (
        input  I_Req, I_Rd_V, I_Rd_No, I_Rd_Idx,
        input  I_We, I_Wr_Idx, I_Data,
        input  I_Rsv, I_Rsv_Idx, I_Clr,
        output O_Valid, O_Data, O_Busy
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register bank with pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module regfile_mp #(
    parameter int NUM_REGS   = 64,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 3,
    parameter int IDX_WIDTH  = $clog2(NUM_REGS),
    parameter int NO_WIDTH   = 2,
    parameter int BANK_ID    = 1
) (
    input  logic        clock,
    input  logic        reset,
    regfile_mp_if.slave bus
);
    logic [DATA_WIDTH-1:0]        regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]        regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]          pend_q, pend_d;
    logic [NUM_RD-1:0]            valid_q, valid_d;
    logic [NUM_RD-1:0]            busy_q, busy_d;
    logic [NUM_RD*DATA_WIDTH-1:0] data_q, data_d;
    logic                         wr_ok, rsv_ok;

    function automatic logic in_range(input logic [IDX_WIDTH-1:0] idx);
        return {1'b0, idx} < (IDX_WIDTH+1)'(NUM_REGS);
    endfunction

    // Out-of-range targets only exist for non-power-of-2 banks
    assign wr_ok  = bus.I_We  & in_range(bus.I_Wr_Idx);
    assign rsv_ok = bus.I_Rsv & in_range(bus.I_Rsv_Idx);

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [IDX_WIDTH-1:0]  idx;
        logic [NO_WIDTH-1:0]   no;
        logic                  re;
        logic [DATA_WIDTH-1:0] rdata;
        logic                  rbusy;

        assign idx = bus.I_Rd_Idx[k*IDX_WIDTH +: IDX_WIDTH];
        assign no  = bus.I_Rd_No[k*NO_WIDTH +: NO_WIDTH];
        assign re  = bus.I_Req & bus.I_Rd_V[k]
                   & (no == NO_WIDTH'(BANK_ID));

        always_comb begin
            rdata = '0;
            rbusy = 1'b0;
            if (in_range(idx)) begin
                rdata = regs_q[idx];
                rbusy = pend_q[idx];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && !bus.I_Clr && (bus.I_Wr_Idx == idx)) begin
                rdata = bus.I_Data;
                rbusy = rsv_ok && (bus.I_Rsv_Idx == idx);
            end
`endif
        end

        assign valid_d[k] = re;
        assign busy_d[k]  = re ? rbusy : busy_q[k];
        assign data_d[k*DATA_WIDTH +: DATA_WIDTH] =
            re ? rdata : data_q[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Reserve is applied after write so it wins on a shared index
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (bus.I_Clr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
            end
            pend_d = '0;
        end else begin
            if (wr_ok) begin
                regs_d[bus.I_Wr_Idx] = bus.I_Data;
                pend_d[bus.I_Wr_Idx] = 1'b0;
            end
            if (rsv_ok) begin
                pend_d[bus.I_Rsv_Idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pend_q  <= '0;
            valid_q <= '0;
            busy_q  <= '0;
            data_q  <= '0;
        end else begin
            regs_q  <= regs_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
        end
    end

    assign bus.O_Valid = valid_q;
    assign bus.O_Data  = data_q;
    assign bus.O_Busy  = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp (3 ports, bank 1).
// Expected read results are queued at drive time and popped after the edge.
module tb_regfile_mp;
    localparam int NR = 3;
    localparam int DW = 32;
    localparam int IW = 6;
    localparam int NW = 2;

    typedef struct packed {
        logic [NR-1:0]    v;
        logic [NR*DW-1:0] d;
        logic [NR-1:0]    b;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    logic [DW-1:0]    mregs [64];
    logic [63:0]      mpend;
    logic [NR-1:0]    mv, mb;
    logic [NR*DW-1:0] md;

    regfile_mp_if #(.NUM_RD(NR), .DATA_WIDTH(DW), .IDX_WIDTH(IW),
                    .NO_WIDTH(NW)) bus ();

    regfile_mp #(.NUM_REGS(64), .DATA_WIDTH(DW), .NUM_RD(NR),
                 .NO_WIDTH(NW), .BANK_ID(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [NR*DW-1:0] got,
                       input logic [NR*DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.I_Req = 0; bus.I_Rd_V = '0; bus.I_Rd_No = '0;
        bus.I_Rd_Idx = '0; bus.I_We = 0; bus.I_Wr_Idx = '0;
        bus.I_Data = '0; bus.I_Rsv = 0; bus.I_Rsv_Idx = '0;
        bus.I_Clr = 0;
    endtask

    task automatic rd(input int k, input int idx, input int no = 1);
        bus.I_Req = 1;
        bus.I_Rd_V[k] = 1'b1;
        bus.I_Rd_No[k*NW +: NW] = NW'(no);
        bus.I_Rd_Idx[k*IW +: IW] = IW'(idx);
    endtask

    task automatic wr(input int idx, input logic [DW-1:0] d);
        bus.I_We = 1; bus.I_Wr_Idx = IW'(idx); bus.I_Data = d;
    endtask

    task automatic rsv(input int idx);
        bus.I_Rsv = 1; bus.I_Rsv_Idx = IW'(idx);
    endtask

    task automatic mreset();
        for (int i = 0; i < 64; i++) mregs[i] = '0;
        mpend = '0; mv = '0; mb = '0; md = '0;
    endtask

    task automatic step(input string tag);
        exp_t e;
        logic [IW-1:0] idx;
        logic [DW-1:0] nd;
        logic nb, re;
        for (int k = 0; k < NR; k++) begin
            re = bus.I_Req && bus.I_Rd_V[k]
                 && (bus.I_Rd_No[k*NW +: NW] == 2'd1);
            mv[k] = re;
            if (re) begin
                idx = bus.I_Rd_Idx[k*IW +: IW];
                nd = mregs[idx];
                nb = mpend[idx];
`ifdef REGFILE_BYPASS_EN
                if (bus.I_We && !bus.I_Clr && bus.I_Wr_Idx == idx) begin
                    nd = bus.I_Data;
                    nb = bus.I_Rsv && (bus.I_Rsv_Idx == idx);
                end
`endif
                md[k*DW +: DW] = nd;
                mb[k] = nb;
            end
        end
        sb.push_back('{v: mv, d: md, b: mb});
        if (bus.I_Clr) begin
            for (int i = 0; i < 64; i++) mregs[i] = '0;
            mpend = '0;
        end else begin
            if (bus.I_We) begin
                mregs[bus.I_Wr_Idx] = bus.I_Data;
                mpend[bus.I_Wr_Idx] = 1'b0;
            end
            if (bus.I_Rsv) mpend[bus.I_Rsv_Idx] = 1'b1;
        end
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".v"}, (NR*DW)'(bus.O_Valid), (NR*DW)'(e.v));
            chk({tag, ".d"}, bus.O_Data, e.d);
            chk({tag, ".b"}, (NR*DW)'(bus.O_Busy), (NR*DW)'(e.b));
        end
        idle();
    endtask

    initial begin
        idle();
        mreset();
        repeat (3) @(posedge clock);
        #1;
        chk("rst.v", (NR*DW)'(bus.O_Valid), '0);
        chk("rst.d", bus.O_Data, '0);
        chk("rst.b", (NR*DW)'(bus.O_Busy), '0);
        reset = 1;

        for (int k = 0; k < NR; k++) rd(k, 5);
        step("rd5_all");
        wr(7, 32'hDEADBEEF);
        step("wr7");
        rd(2, 7);
        step("rd7_p2");

        rd(0, 7, 2);
        rd(1, 7);
        bus.I_Rd_V[1] = 1'b0;
        step("bank_filt");
        rd(0, 7);
        bus.I_Req = 0;
        step("no_req");

        rsv(9);
        step("rsv9");
        for (int k = 0; k < NR; k++) rd(k, 9);
        step("rd9_busy");
        wr(9, 32'h55);
        step("wr9");
        rd(0, 9); rd(1, 9);
        step("rd9_free");
        wr(9, 32'h66); rsv(9);
        step("wr_rsv9");
        rd(1, 9);
        step("rd9_rsv_win");

        wr(3, 32'h11);
        step("wr3_old");
        rd(0, 3); wr(3, 32'h22);
        step("rdwr3");
        rd(0, 3);
        step("rd3_new");
        rd(2, 3); wr(3, 32'h33); rsv(3);
        step("rdwr_rsv3");

        wr(12, 32'hAB);
        step("wr12");
        rd(0, 7); wr(4, 32'h44); bus.I_Clr = 1;
        step("clr_rd7");
        rd(0, 4); rd(1, 7); rd(2, 9);
        step("post_clr");

        for (int n = 0; n < 40; n++) begin
            bus.I_Req = 1'($urandom_range(0, 3) != 0);
            for (int k = 0; k < NR; k++) begin
                bus.I_Rd_V[k] = 1'($urandom_range(0, 1));
                bus.I_Rd_No[k*NW +: NW] = NW'($urandom_range(0, 3));
                bus.I_Rd_Idx[k*IW +: IW] = IW'($urandom_range(0, 7));
            end
            bus.I_We = 1'($urandom_range(0, 1));
            bus.I_Wr_Idx = IW'($urandom_range(0, 7));
            bus.I_Data = $urandom;
            bus.I_Rsv = 1'($urandom_range(0, 2) == 0);
            bus.I_Rsv_Idx = IW'($urandom_range(0, 7));
            bus.I_Clr = 1'($urandom_range(0, 15) == 0);
            step("rand");
        end

        wr(12, 32'hAB);
        step("wr12b");
        rd(0, 12); rd(1, 12);
        step("pre_rst");
        rd(0, 12); rd(1, 12);
        #2;
        reset = 0;
        #1;
        chk("rst_mid.v", (NR*DW)'(bus.O_Valid), '0);
        chk("rst_mid.d", bus.O_Data, '0);
        @(posedge clock);
        #1;
        chk("rst_hold.v", (NR*DW)'(bus.O_Valid), '0);
        idle();
        reset = 1;
        mreset();
        step("rst_rel");
        rd(0, 12);
        step("rst_wiped");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register bank for the TPU backend; successor to the fixed two-source register file.
- Sits between the Index stage and the execution lanes.
- Each read port is gated by its own valid bit and a bank-number match, and returns registered data one cycle later.
- Adds a per-register pending scoreboard, synchronous bulk clear, and optional write-to-read bypass.

Parameters:
NUM_REGS, 64, number of registers in the bank
DATA_WIDTH, 32, register width in bits
NUM_RD, 3, number of independent read ports
IDX_WIDTH, $clog2(NUM_REGS), register index width
NO_WIDTH, 2, width of the bank-number field carried with each index
BANK_ID, 1, bank number this instance answers to

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
I_Req  in  1  request from Index stage; qualifies all reads
I_Rd_V  in  NUM_RD  per-port index valid
I_Rd_No  in  NUM_RD*NO_WIDTH  per-port bank number
I_Rd_Idx  in  NUM_RD*IDX_WIDTH  per-port read index
I_We  in  1  write enable
I_Wr_Idx  in  IDX_WIDTH  write index
I_Data  in  DATA_WIDTH  write-back data
I_Rsv  in  1  reserve destination (mark pending)
I_Rsv_Idx  in  IDX_WIDTH  register to reserve
I_Clr  in  1  synchronous clear of all registers and pending bits
O_Valid  out  NUM_RD  per-port read data valid, single-cycle pulse
O_Data  out  NUM_RD*DATA_WIDTH  per-port read data
O_Busy  out  NUM_RD  per-port: source was pending at read time

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers = 0, all pending bits = 0.
  - O_Valid = 0, O_Data = 0, O_Busy = 0.
  - Takes effect immediately mid-operation; in-flight reads are discarded.
- Read enable, port k: Re[k] = I_Req & I_Rd_V[k] & (I_Rd_No[k] == BANK_ID).
- Read latency is 1 cycle. When Re[k] is high at edge t:
  - O_Data[k] and O_Busy[k] register the values sampled at t.
  - O_Valid[k] = 1 during cycle t+1.
- When Re[k] is low: O_Valid[k] = 0, O_Data[k] and O_Busy[k] hold their previous values.
- Read ports are fully independent; any ports may read the same index in the same cycle.
- Write: if I_We, reg[I_Wr_Idx] <= I_Data at the edge, and pending[I_Wr_Idx] is cleared.
- Reserve: if I_Rsv, pending[I_Rsv_Idx] <= 1.
  - If I_Rsv and I_We target the same index in the same cycle, reserve wins: the register is written and the pending bit ends at 1.
- O_Busy[k] = pending[idx] as sampled at the read edge, before that edge's update.
- I_Clr:
  - all registers and pending bits become 0 at the edge.
  - Overrides I_We and I_Rsv in the same cycle.
  - Reads issued in the same cycle return the pre-clear contents.
- Out-of-range index (only possible when NUM_REGS is not a power of 2):
  - writes and reserves are ignored.
  - reads return data 0, busy 0, valid still asserted.
- Read and write of the same index in the same cycle, without bypass: read returns the old value; O_Busy reflects the old pending bit.
- No stall or backpressure: one request per cycle accepted unconditionally.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: when Re[k] & I_We & (I_Rd_Idx[k] == I_Wr_Idx) in the same cycle:
  - O_Data[k] = I_Data (forwarded).
  - O_Busy[k] = 0, unless I_Rsv targets the same index that cycle, in which case O_Busy[k] = 1.
  - I_Clr in the same cycle suppresses the bypass; the pre-clear value is returned.
- Undefined: no forwarding; same-cycle read returns the pre-write value and pending bit.

Test Plan:
- Reset then read: reset low 3 cycles, release, read idx 5 on all ports with No=BANK_ID -> next cycle O_Valid=3'b111, O_Data all 0, O_Busy 0.
- Write/read: write idx 7 = 0xDEADBEEF, next cycle read idx 7 on port 2 -> one cycle later O_Data[2]=0xDEADBEEF, O_Valid=3'b100.
- Bank filter: read idx 7 with No=2 on port 0, with I_Rd_V=0 on port 1 -> O_Valid stays 0, O_Data holds previous value.
- Scoreboard: reserve idx 9 -> read idx 9 gives O_Busy=1; write idx 9 = 0x55, then read -> O_Busy=0, O_Data=0x55. Same-cycle I_Rsv and I_We on idx 9 -> pending stays 1.
- Same-cycle read/write idx 3 (old 0x11, new 0x22): with REGFILE_BYPASS_EN -> 0x22; without -> 0x11, with 0x22 on the following read.
- Clear and mid-op reset: I_Clr with concurrent write to idx 4 -> idx 4 reads 0. Assert reset during a read cycle -> O_Valid drops to 0 immediately, no pulse after release.
